// File: rtl/alu_pkg.sv
// Shared types for the sequential MIPS ALU: operation encodings and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_ABS   = 4'd2,
    OP_PASS  = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_SLT   = 4'd7,
    OP_MULTU = 4'd8,
    OP_DIVU  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

endpackage

// File: rtl/alu_iter_div.sv
// Restoring unsigned divider, one quotient bit per clock, WIDTH iterations.
// done_o is high during the final iteration; quot_o/rem_o carry that iteration's result.
module alu_iter_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             run_q, run_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   shifted, diff;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             last;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    // A clear borrow bit means the partial remainder covers the divisor.
    if (!diff[WIDTH]) begin
      rem_step = diff[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = shifted[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end
    last = run_q && (cnt_q == CNT_W'(WIDTH-1));

    run_d = run_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (start_i) begin
      run_d = 1'b1;
      cnt_d = '0;
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (run_q) begin
      cnt_d = cnt_q + 1'b1;
      rem_d = rem_step;
      quo_d = quo_step;
      if (last) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

  assign done_o = last;
  assign quot_o = quo_step;
  assign rem_o  = rem_step;

endmodule

// File: rtl/alu_seq.sv
// Registered MIPS ALU with iterative MULTU/DIVU and a valid/ready handshake.
// ALU_SEQ_DIV_EN adds the restoring divider; without it DIVU returns 0/0 with ovf set.
//
// state | meaning
// IDLE  | waiting for an operation
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide running in alu_iter_div
// DONE  | result valid, held until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mhi_q, mhi_d;
  logic [WIDTH-1:0] mlo_q, mlo_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, busy_q;

  logic             accept;
  logic [WIDTH-1:0] sum, dif, sc_lo;
  logic             sc_ovf;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

`ifdef ALU_SEQ_DIV_EN
  logic             div_start, div_done;
  logic [WIDTH-1:0] div_quot, div_rem;

  alu_iter_div #(.WIDTH(WIDTH)) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .dividend_i (a),
    .divisor_i  (b),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );
`endif

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum    = a + b;
    dif    = a - b;
    sc_lo  = sum;
    sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    case (op)
      OP_SUB: begin
        sc_lo  = dif;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ABS: begin
        sc_lo  = a[WIDTH-1] ? (~a + 1'b1) : a;
        sc_ovf = (a == MSB_ONLY);
      end
      OP_PASS: begin sc_lo = a;     sc_ovf = 1'b0; end
      OP_AND:  begin sc_lo = a & b; sc_ovf = 1'b0; end
      OP_OR:   begin sc_lo = a | b; sc_ovf = 1'b0; end
      OP_XOR:  begin sc_lo = a ^ b; sc_ovf = 1'b0; end
      OP_SLT:  begin sc_lo = {{(WIDTH-1){1'b0}}, (a < b)}; sc_ovf = 1'b0; end
      default: ;
    endcase
  end

  // Product shifts right through {mhi, mlo}; mlo starts as the multiplier.
  assign mul_sum   = {1'b0, mhi_q} + (mlo_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], mlo_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mhi_d   = mhi_q;
    mlo_d   = mlo_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`ifdef ALU_SEQ_DIV_EN
    div_start = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && out_ready && !in_valid) state_d = IDLE;
        if (accept) begin
          if (op == OP_MULTU) begin
            state_d = MUL;
            cnt_d   = '0;
            mcand_d = a;
            mhi_d   = '0;
            mlo_d   = b;
          end else if (op == OP_DIVU) begin
`ifdef ALU_SEQ_DIV_EN
            if (b != '0) begin
              state_d   = DIV;
              div_start = 1'b1;
            end else begin
              state_d = DONE;
              lo_d    = '1;
              hi_d    = a;
              zero_d  = 1'b0;
              ovf_d   = 1'b1;
            end
`else
            state_d = DONE;
            lo_d    = '0;
            hi_d    = '0;
            zero_d  = 1'b1;
            ovf_d   = 1'b1;
`endif
          end else begin
            state_d = DONE;
            lo_d    = sc_lo;
            hi_d    = '0;
            zero_d  = (sc_lo == '0);
            ovf_d   = sc_ovf;
          end
        end
      end
      MUL: begin
        mhi_d = mul_hi_nx;
        mlo_d = mul_lo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = DONE;
          lo_d    = mul_lo_nx;
          hi_d    = mul_hi_nx;
          zero_d  = (mul_lo_nx == '0);
          ovf_d   = 1'b0;
        end
      end
      DIV: begin
`ifdef ALU_SEQ_DIV_EN
        if (div_done) begin
          state_d = DONE;
          lo_d    = div_quot;
          hi_d    = div_rem;
          zero_d  = (div_quot == '0);
          ovf_d   = 1'b0;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mhi_q       <= '0;
      mlo_q       <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mhi_q       <= mhi_d;
      mlo_q       <= mlo_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d == MUL) || (state_d == DIV);
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule
